// File: rtl/tetris_pkg.sv
// Shared types for the playfield executors.
package tetris_pkg;

  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eSCAN = 2'd1,
    eFILL = 2'd2,
    eDONE = 2'd3
  } exec_clear_state_e;

endpackage

// File: rtl/executor_clear.sv
// Single-pass line-clear executor: compacts surviving rows toward row 0,
// zero-fills the vacated top rows and reports the cleared rows.
module executor_clear
  import tetris_pkg::*;
#(
  parameter  int width_p   = 16,
  parameter  int height_p  = 32,
  localparam int addr_w_lp = $clog2(height_p),
  localparam int cnt_w_lp  = $clog2(height_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,

  input  logic                 v_i,
  output logic                 ready_o,

  output logic [addr_w_lp-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]   mm_read_data_i,
  output logic [addr_w_lp-1:0] mm_write_addr_o,
  output logic [width_p-1:0]   mm_write_data_o,
  output logic                 mm_write_v_o,

  output logic                 v_o,
  input  logic                 yumi_i,
  output logic [cnt_w_lp-1:0]  clear_count_o,
  output logic [height_p-1:0]  clear_mask_o
);

  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(height_p - 1);

  exec_clear_state_e     state_r, state_n;
  logic [addr_w_lp-1:0]  rd_ptr_r, rd_ptr_n;
  logic [addr_w_lp-1:0]  wr_ptr_r, wr_ptr_n;
  logic [cnt_w_lp-1:0]   count_r, count_n;
  logic [height_p-1:0]   mask_r, mask_n;

  logic row_full;
  assign row_full = &mm_read_data_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eIDLE;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      mask_r   <= '0;
    end else begin
      state_r  <= state_n;
      rd_ptr_r <= rd_ptr_n;
      wr_ptr_r <= wr_ptr_n;
      count_r  <= count_n;
      mask_r   <= mask_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n         = state_r;
    rd_ptr_n        = rd_ptr_r;
    wr_ptr_n        = wr_ptr_r;
    count_n         = count_r;
    mask_n          = mask_r;
    ready_o         = 1'b0;
    v_o             = 1'b0;
    mm_read_addr_o  = '0;
    mm_write_addr_o = '0;
    mm_write_data_o = '0;
    mm_write_v_o    = 1'b0;

    unique case (state_r)
      eIDLE: begin
        ready_o  = 1'b1;
        rd_ptr_n = '0;
        wr_ptr_n = '0;
        count_n  = '0;
        mask_n   = '0;
        if (v_i) state_n = eSCAN;
      end

      eSCAN: begin
        mm_read_addr_o  = rd_ptr_r;
        mm_write_addr_o = wr_ptr_r;
        mm_write_data_o = mm_read_data_i;
        if (row_full) begin
          count_n          = count_r + cnt_w_lp'(1);
          mask_n[rd_ptr_r] = 1'b1;
        end else begin
          // A surviving row already in place needs no copy.
          mm_write_v_o = (wr_ptr_r != rd_ptr_r);
          wr_ptr_n     = wr_ptr_r + addr_w_lp'(1);
        end
        if (rd_ptr_r == last_addr_lp) begin
          state_n = (count_n != '0) ? eFILL : eDONE;
        end else begin
          rd_ptr_n = rd_ptr_r + addr_w_lp'(1);
        end
      end

      eFILL: begin
        mm_write_addr_o = wr_ptr_r;
        mm_write_v_o    = 1'b1;
        wr_ptr_n        = wr_ptr_r + addr_w_lp'(1);
        if (wr_ptr_r == last_addr_lp) state_n = eDONE;
      end

      eDONE: begin
        v_o = 1'b1;
        if (yumi_i) state_n = eIDLE;
      end

      default: state_n = eIDLE;
    endcase
  end

  assign clear_count_o = count_r;
  assign clear_mask_o  = mask_r;

endmodule

// File: tb/tb_executor_clear.sv
// Directed bench for executor_clear on a 4x8 playfield with a behavioural
// combinational-read, clocked-write row memory.
module tb_executor_clear;

  localparam int W = 4;
  localparam int H = 8;
  localparam int AW = $clog2(H);
  localparam int CW = $clog2(H + 1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i, ready_o;
  logic [AW-1:0] mm_read_addr_o, mm_write_addr_o;
  logic [W-1:0]  mm_read_data_i, mm_write_data_o;
  logic          mm_write_v_o;
  logic          v_o, yumi_i;
  logic [CW-1:0] clear_count_o;
  logic [H-1:0]  clear_mask_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mem       [H];
  logic [W-1:0] init_rows [H];
  logic         load_en = 1'b0;
  int           n_writes = 0;

  executor_clear #(.width_p(W), .height_p(H)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .ready_o         (ready_o),
    .mm_read_addr_o  (mm_read_addr_o),
    .mm_read_data_i  (mm_read_data_i),
    .mm_write_addr_o (mm_write_addr_o),
    .mm_write_data_o (mm_write_data_o),
    .mm_write_v_o    (mm_write_v_o),
    .v_o             (v_o),
    .yumi_i          (yumi_i),
    .clear_count_o   (clear_count_o),
    .clear_mask_o    (clear_mask_o)
  );

  always #5 clk_i = ~clk_i;

  assign mm_read_data_i = mem[mm_read_addr_o];

  always @(posedge clk_i) begin
    if (load_en) begin
      for (int i = 0; i < H; i++) mem[i] <= init_rows[i];
    end else if (mm_write_v_o) begin
      mem[mm_write_addr_o] <= mm_write_data_o;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Rows packed 4 bits each, row 0 in the low nibble.
  task automatic load(input logic [31:0] rows);
    @(negedge clk_i);
    for (int i = 0; i < H; i++) init_rows[i] = rows[4*i +: 4];
    load_en = 1'b1;
    @(negedge clk_i);
    load_en = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] rows);
    logic [31:0] packed_mem;
    for (int i = 0; i < H; i++) packed_mem[4*i +: 4] = mem[i];
    check(tag, packed_mem, rows);
  endtask

  // Accept a request, wait for v_o (bounded), check latency and results.
  task automatic run_clear(input string tag, input int exp_lat, input int exp_cnt,
                           input logic [31:0] exp_mask, input int exp_wr);
    int   lat;
    int   w0;
    logic seen;
    @(negedge clk_i);
    check({tag, " ready before accept"}, ready_o, 1);
    v_i = 1'b1;
    w0  = n_writes;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    check({tag, " ready low in scan"}, ready_o, 0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (v_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " v_o seen"}, seen, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " count"}, clear_count_o, exp_cnt);
    check({tag, " mask"}, clear_mask_o, exp_mask);
    check({tag, " writes"}, n_writes - w0, exp_wr);
  endtask

  task automatic ack();
    @(negedge clk_i);
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
  endtask

  initial begin
    int w0;
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    yumi_i    = 1'b0;
    for (int i = 0; i < H; i++) mem[i] = '0;

    #2;
    check("reset ready", ready_o, 1);
    check("reset v_o", v_o, 0);
    check("reset wr_v", mm_write_v_o, 0);
    check("reset count", clear_count_o, 0);
    check("reset mask", clear_mask_o, 0);
    #10;
    reset_n_i = 1'b1;

    // Empty field: nothing cleared, nothing written.
    load(32'h0000_0000);
    run_clear("empty", 8, 0, 32'h00, 0);
    check_mem("empty mem", 32'h0000_0000);
    ack();

    // Bottom row full: three rows shift down by one, top row filled.
    load(32'h0000_321F);
    run_clear("one", 9, 1, 32'h01, 8);
    check_mem("one mem", 32'h0000_0321);
    ack();

    // Rows 1 and 3 full, interleaved with survivors.
    load(32'h000_2F4F8);
    run_clear("two", 10, 2, 32'h0A, 7);
    check_mem("two mem", 32'h0000_0248);
    ack();

    // Entire field full: every row cleared, all writes come from FILL.
    load(32'hFFFF_FFFF);
    run_clear("all", 16, 8, 32'hFF, 8);
    check_mem("all mem", 32'h0000_0000);

    // Hold the result without yumi; stray v_i pulses must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      v_i = i[0];
      @(posedge clk_i);
      #1;
      check("hold v_o", v_o, 1);
      check("hold count", clear_count_o, 8);
      check("hold mask", clear_mask_o, 8'hFF);
      check("hold ready", ready_o, 0);
    end
    @(negedge clk_i);
    v_i    = 1'b0;
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ack ready", ready_o, 1);
    check("ack v_o", v_o, 0);
    yumi_i = 1'b0;
    run_clear("b2b", 8, 0, 32'h00, 0);
    ack();

    // Reset in the middle of a scan while a copy write is being driven.
    load(32'h0000_321F);
    @(negedge clk_i);
    v_i = 1'b1;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check("pre-reset write", mm_write_v_o, 1);
    reset_n_i = 1'b0;
    #1;
    check("rst wr_v", mm_write_v_o, 0);
    check("rst ready", ready_o, 1);
    check("rst v_o", v_o, 0);
    check("rst rd addr", mm_read_addr_o, 0);
    check("rst wr addr", mm_write_addr_o, 0);
    check("rst wr data", mm_write_data_o, 0);
    check("rst count", clear_count_o, 0);
    check("rst mask", clear_mask_o, 0);
    w0 = n_writes;
    @(posedge clk_i);
    #1;
    check("rst no write", n_writes - w0, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post-rst ready", ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
